// File: rtl/btod_arbiter.sv
// btod_arbiter: round-robin arbiter in front of one shared BCD-to-decimal decoder.
// Four requesters compete for the decoder. The winner's code is registered onto
// dec_a..dec_d and held for SETTLE cycles. The decoder output is then captured
// into result, and ack pulses to the winner.
// Optional build macro: BTOD_CODE_CHECK_EN. When it is defined, codes 10..15 drive a
// zero nibble, produce result = 0 and raise err.
module btod_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] code,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic [8:0]  result,
  output logic        err,
  output logic        busy,
  output logic        dec_a,
  output logic        dec_b,
  output logic        dec_c,
  output logic        dec_d,
  input  logic [8:0]  dec_y
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_ptr;
  logic [3:0]  r_cnt;
  logic [3:0]  r_ack;
  logic [1:0]  r_grant;
  logic [8:0]  r_result;
  logic        r_err;
  logic [3:0]  r_dec;
  logic        w_any;
  logic [1:0]  w_pick;
  logic [1:0]  w_idx;
  logic [3:0]  w_code_sel;
  logic [3:0]  w_dec_nib;
  logic        w_last;

`ifdef BTOD_CODE_CHECK_EN
  // Validity of the latched code. Later changes on the code bus cannot affect it.
  logic        r_bad;
  logic        w_bad;
  assign w_bad     = (w_code_sel > 4'd9);
  assign w_dec_nib = w_bad ? 4'd0 : w_code_sel;
`else
  assign w_dec_nib = w_code_sel;
`endif

  assign w_any      = |req;
  assign w_code_sel = code[{w_pick, 2'b00} +: 4];
  assign w_last     = (r_cnt <= 4'd1);

  // Pick the first requester at or after r_ptr, wrapping 3 -> 0.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    w_pick = r_ptr;
    w_idx  = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (req[w_idx]) w_pick = w_idx;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all flops update together.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any)  w_next = S_DRIVE;
      S_DRIVE: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs that come directly from the state.
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Datapath: grant capture, settle countdown, decoder sampling and the ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_grant  <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_dec    <= '0;
`ifdef BTOD_CODE_CHECK_EN
      r_bad    <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_dec   <= w_dec_nib;
            r_cnt   <= 4'(SETTLE);
`ifdef BTOD_CODE_CHECK_EN
            r_bad   <= w_bad;
`endif
          end
        end
        S_DRIVE: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_last) begin
`ifdef BTOD_CODE_CHECK_EN
            r_result <= r_bad ? 9'd0 : dec_y;
            r_err    <= r_bad;
`else
            r_result <= dec_y;
            r_err    <= 1'b0;
`endif
            r_dec    <= '0;
          end
        end
        S_DONE: begin
          r_ack <= 4'b0001 << r_grant;
          r_ptr <= r_grant + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign ack      = r_ack;
  assign grant_id = r_grant;
  assign result   = r_result;
  assign err      = r_err;
  assign dec_a    = r_dec[3];
  assign dec_b    = r_dec[2];
  assign dec_c    = r_dec[1];
  assign dec_d    = r_dec[0];

endmodule

// File: tb/tb_btod_arbiter.sv
// Testbench for btod_arbiter. A transaction-level reference model predicts the
// round-robin winner, the ack latency, the decoded result and the flags.
// A behavioural decoder drives dec_y from dec_a..dec_d.
module tb_btod_arbiter;

  localparam int unsigned S1 = 1;
  localparam int unsigned S3 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] code;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic [8:0]  result;
  logic        err, busy, dec_a, dec_b, dec_c, dec_d;
  logic [8:0]  dec_y;

  logic [3:0]  req3;
  logic [15:0] code3;
  logic [3:0]  ack3;
  logic [1:0]  grant_id3;
  logic [8:0]  result3;
  logic        err3, busy3, dec_a3, dec_b3, dec_c3, dec_d3;
  logic [8:0]  dec_y3;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] m_ptr = 2'd0;

  always #5 clk = ~clk;

  // Behavioural decoder: digit k lights bit k-1, digit 0 lights nothing.
  // Codes 10..15 light every output, so passing them through is easy to see.
  function automatic logic [8:0] dec_model(input logic [3:0] v);
    if (v == 4'd0)       return 9'd0;
    else if (v <= 4'd9)  return 9'd1 << (v - 4'd1);
    else                 return 9'h1FF;
  endfunction

  assign dec_y  = dec_model({dec_a, dec_b, dec_c, dec_d});
  assign dec_y3 = dec_model({dec_a3, dec_b3, dec_c3, dec_d3});

  btod_arbiter #(.SETTLE(S1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .code(code), .ack(ack), .grant_id(grant_id),
    .result(result), .err(err), .busy(busy),
    .dec_a(dec_a), .dec_b(dec_b), .dec_c(dec_c), .dec_d(dec_d), .dec_y(dec_y));

  btod_arbiter #(.SETTLE(S3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .code(code3), .ack(ack3), .grant_id(grant_id3),
    .result(result3), .err(err3), .busy(busy3),
    .dec_a(dec_a3), .dec_b(dec_b3), .dec_c(dec_c3), .dec_d(dec_d3), .dec_y(dec_y3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin model: the first set request at or after the pointer.
  function automatic logic [1:0] exp_pick(input logic [3:0] r, input logic [1:0] p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return 2'((p + i) % 4);
    return p;
  endfunction

  function automatic logic [3:0] exp_nib(input logic [3:0] c);
`ifdef BTOD_CODE_CHECK_EN
    return (c > 4'd9) ? 4'd0 : c;
`else
    return c;
`endif
  endfunction

  function automatic logic [8:0] exp_res(input logic [3:0] c);
`ifdef BTOD_CODE_CHECK_EN
    return (c > 4'd9) ? 9'd0 : dec_model(c);
`else
    return dec_model(c);
`endif
  endfunction

  function automatic logic exp_err(input logic [3:0] c);
`ifdef BTOD_CODE_CHECK_EN
    return (c > 4'd9);
`else
    return 1'b0;
`endif
  endfunction

  // Serve one transaction on u_dut. On entry the DUT is idle and the next edge
  // is the grant edge. The task returns #1 after the edge on which ack rises.
  task automatic serve_one(input bit drop_mid, input bit mutate);
    logic [1:0] g;
    logic [3:0] c;
    int n;
    g = exp_pick(req, m_ptr);
    c = code[{g, 2'b00} +: 4];
    @(posedge clk); #1;
    check("grant_busy", 32'(busy), 32'd1);
    check("grant_id", 32'(grant_id), 32'(g));
    check("grant_dec", 32'({dec_a, dec_b, dec_c, dec_d}), 32'(exp_nib(c)));
    check("grant_ack_low", 32'(ack), 32'd0);
    if (mutate)   code[{g, 2'b00} +: 4] = 4'($urandom);
    if (drop_mid) req[g] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n < int'(S1)) check("drive_dec_hold", 32'({dec_a, dec_b, dec_c, dec_d}), 32'(exp_nib(c)));
      if (n == int'(S1)) check("done_dec_zero", 32'({dec_a, dec_b, dec_c, dec_d}), 32'd0);
    end while (ack == 4'd0 && n < 20);
    check("ack_latency", 32'(n), 32'(S1 + 1));
    check("ack_onehot", 32'(ack), 32'(4'b0001 << g));
    check("result", 32'(result), 32'(exp_res(c)));
    check("err", 32'(err), 32'(exp_err(c)));
    check("idle_busy", 32'(busy), 32'd0);
    req[g] = 1'b0;
    m_ptr  = g + 2'd1;
  endtask

  initial begin
    int n3;
    rst = 1'b1; req = '0; code = '0; req3 = '0; code3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_outs", 32'({grant_id, result, err, dec_a, dec_b, dec_c, dec_d}), 32'd0);
    rst = 1'b0;

    // Requester 0 sends digit 7.
    req = 4'b0001; code = 16'h0007;
    serve_one(1'b0, 1'b0);

    // Reset, then all four request at once. The grant order must be 0,1,2,3.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; m_ptr = 2'd0;
    req = 4'b1111; code = 16'h4321;
    for (int k = 0; k < 4; k++) serve_one(1'b0, 1'b1);

    // Requester 1 sends code 12, which is out of range.
    @(posedge clk); #1;
    req = 4'b0010; code = 16'h00C0;
    serve_one(1'b0, 1'b0);

    // Requester 3 drops req while its transaction is in progress.
    // It still gets ack and is not granted again.
    req = 4'b1000; code = 16'h5000;
    serve_one(1'b1, 1'b0);
    @(posedge clk); #1;
    check("no_regrant", 32'(busy), 32'd0);

    // Set the pointer to 3, then abort requester 3 with a reset in DRIVE.
    req = 4'b0100; code = 16'h0900;
    serve_one(1'b0, 1'b0);
    req = 4'b1000; code = 16'h8000;
    @(posedge clk); #1;
    check("abort_grant", 32'(grant_id), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_outs", 32'({grant_id, result, err, dec_a, dec_b, dec_c, dec_d}), 32'd0);
    m_ptr = 2'd0;
    req = 4'b1001; code = 16'h6002;
    serve_one(1'b0, 1'b0);

    // Random traffic. Requests that have not been served keep waiting.
    for (int k = 0; k < 30; k++) begin
      req  = req | 4'($urandom_range(0, 15));
      if (req == 4'd0) req = 4'b0001 << $urandom_range(0, 3);
      code = 16'($urandom);
      serve_one(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    req = '0;

    // SETTLE=3 instance: requester 2 sends digit 0. ack rises four edges after the grant.
    @(posedge clk); #1;
    req3 = 4'b0100; code3 = 16'h0000;
    @(posedge clk); #1;
    check("s3_grant", 32'({busy3, grant_id3}), 32'({1'b1, 2'd2}));
    n3 = 0;
    do begin
      @(posedge clk); #1;
      n3++;
    end while (ack3 == 4'd0 && n3 < 20);
    req3 = '0;
    check("s3_latency", 32'(n3), 32'(S3 + 1));
    check("s3_ack", 32'(ack3), 32'b0100);
    check("s3_result_err", 32'({result3, err3}), 32'd0);
    @(posedge clk); #1;
    check("s3_ack_pulse", 32'(ack3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
